// File: rtl/counter_timer_pkg.sv
// Shared types and constants for the interval-timer controller.
package counter_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/Counter.sv
// Width-parameterised up-counter with synchronous clear and enable gate.
module Counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [width-1:0] cnt
);

    logic [width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = cnt_q + width'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/counter_timer_ctrl.sv
// Interval-timer controller: sequences one Counter through start/stop/pause
// and produces tick/done/err pulses in one-shot or periodic mode.
module counter_timer_ctrl
    import counter_timer_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             periodic,
    input  logic [width-1:0] period,
    output logic             busy,
    output logic             tick,
    output logic             done,
    output logic             err,
    output logic [width-1:0] cnt
);

    state_t           state_q, state_d;
    logic [width-1:0] period_r_q, period_r_d;
    logic             mode_r_q, mode_r_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clear, cnt_en, active, terminal;

    // HOLD with pause already dropped counts as running, so each paused
    // cycle costs exactly one cycle of delay.
    always_comb begin
        active     = (state_q != ST_IDLE) && !pause && !stop;
        terminal   = active && (cnt == period_r_q - width'(1));
        cnt_en     = active;
        state_d    = state_q;
        period_r_d = period_r_q;
        mode_r_d   = mode_r_q;
        tick_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        clear      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                clear = 1'b1;
                if (start && !stop) begin
                    if (period != '0) begin
                        period_r_d = period;
                        mode_r_d   = periodic;
                        state_d    = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN, ST_HOLD: begin
                if (stop) begin
                    clear   = 1'b1;
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else if (terminal) begin
                    tick_d = 1'b1;
                    clear  = 1'b1;
                    if (mode_r_q == MODE_ONESHOT) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            period_r_q <= '0;
            mode_r_q   <= MODE_ONESHOT;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            period_r_q <= period_r_d;
            mode_r_q   <= mode_r_d;
            tick_q     <= tick_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    Counter #(.width(width)) u_counter (
        .clk (clk),
        .rst (rst | clear),
        .en  (cnt_en),
        .cnt (cnt)
    );

    assign busy = (state_q != ST_IDLE);
    assign tick = tick_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Self-checking bench: directed scenarios plus randomized run against a
// cycle-level behavioural model of the timer.
module tb_counter_timer_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, stop, pause, periodic;
    logic [W-1:0] period;
    logic         busy, tick, done, err;
    logic [W-1:0] cnt;
    logic [W+3:0] obs;

    int n_pass  = 0;
    int n_total = 0;

    // behavioural model: busy flag, elapsed count, latched interval/mode, pulses
    int m_busy, m_cnt, m_per, m_mode, m_tick, m_done, m_err;

    counter_timer_ctrl #(.width(W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .periodic(periodic), .period(period), .busy(busy), .tick(tick),
        .done(done), .err(err), .cnt(cnt)
    );

    always #5 clk = ~clk;

    assign obs = {busy, tick, done, err, cnt};

    function automatic logic [W+3:0] pk(input int b, input int t, input int d, input int e, input int c);
        return {b[0], t[0], d[0], e[0], c[W-1:0]};
    endfunction

    task automatic model_step();
        m_tick = 0; m_done = 0; m_err = 0;
        if (rst) begin
            m_busy = 0; m_cnt = 0;
        end else if (m_busy == 0) begin
            m_cnt = 0;
            if (start && !stop) begin
                if (period != 0) begin
                    m_busy = 1; m_per = int'(period); m_mode = int'(periodic);
                end else begin
                    m_err = 1;
                end
            end
        end else if (stop) begin
            m_busy = 0; m_cnt = 0;
        end else if (!pause) begin
            if (m_cnt + 1 == m_per) begin
                m_tick = 1; m_cnt = 0;
                if (m_mode == 0) begin m_done = 1; m_busy = 0; end
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; pause = 0; periodic = 0; period = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; step(); step();
        rst = 0;
        n_total++;
        if (obs !== pk(0, 0, 0, 0, 0)) $display("FAIL reset: got %h want %h", obs, pk(0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_oneshot();
        period = 8'd5; periodic = 0; start = 1;
        step(); start = 0;
        for (int j = 0; j < 5; j++) begin
            n_total++;
            if (obs !== pk(1, 0, 0, 0, j)) $display("FAIL oneshot c%0d: got %h want %h", j + 1, obs, pk(1, 0, 0, 0, j));
            else n_pass++;
            step();
        end
        n_total++;
        if (obs !== pk(0, 1, 1, 0, 0)) $display("FAIL oneshot_term: got %h want %h", obs, pk(0, 1, 1, 0, 0));
        else n_pass++;
        step();
        n_total++;
        if (obs !== pk(0, 0, 0, 0, 0)) $display("FAIL oneshot_after: got %h want %h", obs, pk(0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_periodic();
        period = 8'd3; periodic = 1; start = 1;
        step(); start = 0;
        for (int c = 1; c <= 10; c++) begin
            int t;
            t = (c >= 4 && (c - 1) % 3 == 0) ? 1 : 0;
            n_total++;
            if (obs !== pk(1, t, 0, 0, (c - 1) % 3)) $display("FAIL periodic c%0d: got %h want %h", c, obs, pk(1, t, 0, 0, (c - 1) % 3));
            else n_pass++;
            step();
        end
        stop = 1; step(); stop = 0;
        n_total++;
        if (obs !== pk(0, 0, 0, 0, 0)) $display("FAIL periodic_stop: got %h want %h", obs, pk(0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_pause();
        int exp_cnt [1:7];
        exp_cnt = '{0, 1, 1, 1, 2, 3, 0};
        period = 8'd4; periodic = 1; start = 1;
        step(); start = 0;
        for (int c = 1; c <= 7; c++) begin
            int t;
            t = (c == 7) ? 1 : 0;
            n_total++;
            if (obs !== pk(1, t, 0, 0, exp_cnt[c])) $display("FAIL pause c%0d: got %h want %h", c, obs, pk(1, t, 0, 0, exp_cnt[c]));
            else n_pass++;
            pause = (c == 2 || c == 3);
            step();
        end
        pause = 0; stop = 1; step(); stop = 0;
    endtask

    task automatic test_stop_terminal();
        period = 8'd3; periodic = 1; start = 1;
        step(); start = 0;
        step(); step();
        n_total++;
        if (obs !== pk(1, 0, 0, 0, 2)) $display("FAIL stop_pre: got %h want %h", obs, pk(1, 0, 0, 0, 2));
        else n_pass++;
        stop = 1; step(); stop = 0;
        n_total++;
        if (obs !== pk(0, 0, 0, 0, 0)) $display("FAIL stop_term: got %h want %h", obs, pk(0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_err_and_restart();
        period = 8'd0; start = 1;
        step(); start = 0;
        n_total++;
        if (obs !== pk(0, 0, 0, 1, 0)) $display("FAIL err_pulse: got %h want %h", obs, pk(0, 0, 0, 1, 0));
        else n_pass++;
        step();
        n_total++;
        if (obs !== pk(0, 0, 0, 0, 0)) $display("FAIL err_clear: got %h want %h", obs, pk(0, 0, 0, 0, 0));
        else n_pass++;
        period = 8'd5; periodic = 1; start = 1;
        step(); period = 8'd2;
        for (int j = 0; j < 5; j++) begin
            n_total++;
            if (obs !== pk(1, 0, 0, 0, j)) $display("FAIL start_in_run c%0d: got %h want %h", j + 1, obs, pk(1, 0, 0, 0, j));
            else n_pass++;
            step();
        end
        n_total++;
        if (obs !== pk(1, 1, 0, 0, 0)) $display("FAIL start_in_run_tick: got %h want %h", obs, pk(1, 1, 0, 0, 0));
        else n_pass++;
        start = 0; stop = 1; step(); stop = 0;
    endtask

    task automatic test_rst_mid();
        period = 8'd10; periodic = 1; start = 1;
        step(); start = 0;
        step(); step(); step();
        rst = 1; step(); rst = 0;
        n_total++;
        if (obs !== pk(0, 0, 0, 0, 0)) $display("FAIL rst_mid: got %h want %h", obs, pk(0, 0, 0, 0, 0));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        period = 8'd2; periodic = 0; start = 1;
        step(); start = 0;
        step(); step();
        n_total++;
        if (obs !== pk(0, 1, 1, 0, 0)) $display("FAIL b2b_done: got %h want %h", obs, pk(0, 1, 1, 0, 0));
        else n_pass++;
        period = 8'd1; periodic = 1; start = 1;
        step(); start = 0;
        n_total++;
        if (obs !== pk(1, 0, 0, 0, 0)) $display("FAIL b2b_restart: got %h want %h", obs, pk(1, 0, 0, 0, 0));
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            step();
            n_total++;
            if (obs !== pk(1, 1, 0, 0, 0)) $display("FAIL period1_tick c%0d: got %h want %h", c, obs, pk(1, 1, 0, 0, 0));
            else n_pass++;
        end
        stop = 1; step(); stop = 0;
    endtask

    task automatic test_random();
        idle_inputs();
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 19) == 0);
            pause    = ($urandom_range(0, 4) == 0);
            periodic = $urandom_range(0, 1) == 1;
            period   = W'($urandom_range(0, 7));
            rst      = ($urandom_range(0, 199) == 0);
            step();
            n_total++;
            if (obs !== pk(m_busy, m_tick, m_done, m_err, m_cnt))
                $display("FAIL random i%0d: got %h want %h", i, obs, pk(m_busy, m_tick, m_done, m_err, m_cnt));
            else n_pass++;
        end
        idle_inputs(); rst = 0;
    endtask

    initial begin
        m_busy = 0; m_cnt = 0; m_per = 1; m_mode = 0;
        m_tick = 0; m_done = 0; m_err = 0;
        rst = 1;
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_stop_terminal();
        test_err_and_restart();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
